// File: rtl/activity_counter_array.sv
// rtl/activity_counter_array.sv - duty-paced lane activity generator with bounded run/stop control
module activity_counter_array #(
    parameter int             NUM   = 512,
    parameter int             W     = 32,
    parameter int             CNT_W = 32,
    parameter logic [W-1:0]   POLY  = W'(32'hB4BC_D35C)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [1:0]              mode,
    input  logic [8:0]              duty,
    input  logic [CNT_W-1:0]        run_cycles,
    input  logic [$clog2(NUM)-1:0]  sample_sel,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        cycles,
    output logic [CNT_W-1:0]        steps,
    output logic [W-1:0]            sample_data,
    output logic [W-1:0]            sig
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_INC    = 2'd0;
    localparam logic [1:0] MODE_DEC    = 2'd1;
    localparam logic [1:0] MODE_LFSR   = 2'd2;
    localparam logic [1:0] MODE_INVERT = 2'd3;

    state_t             state;
    state_t             state_next;
    logic [1:0]         mode_q;
    logic [8:0]         duty_q;
    logic [CNT_W-1:0]   run_cycles_q;
    logic [7:0]         acc;
    logic [W-1:0]       lanes [NUM];

    logic               launch;
    logic               advance;
    logic [8:0]         sum;
    logic               step_en;
    logic [CNT_W-1:0]   cycles_inc;
    logic [W-1:0]       sig_next;
    logic [W-1:0]       sample_next;

    // One step of a single lane under the latched mode.
    function automatic logic [W-1:0] step_lane(input logic [W-1:0] x, input logic [1:0] m);
        logic [W-1:0] r;
        case (m)
            MODE_INC:    r = x + W'(1);
            MODE_DEC:    r = x - W'(1);
            MODE_LFSR:   r = (x >> 1) ^ (x[0] ? POLY : '0);
            MODE_INVERT: r = ~x;
            default:     r = x;
        endcase
        return r;
    endfunction

    // Duty accumulator: the carry out of acc + duty is the step enable for this cycle.
    always_comb begin
        sum        = {1'b0, acc} + duty_q;
        step_en    = sum[8];
        cycles_inc = cycles + CNT_W'(1);
    end

    // Next-state logic; a stop in RUN takes priority over the cycle budget expiring.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    launch     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = DONE;
                end else begin
                    advance = 1'b1;
                    if ((run_cycles_q != '0) && (cycles_inc == run_cycles_q)) begin
                        state_next = DONE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

    // Run configuration is captured only when a run is launched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= '0;
            duty_q       <= '0;
            run_cycles_q <= '0;
        end else if (launch) begin
            mode_q       <= mode;
            duty_q       <= duty;
            run_cycles_q <= run_cycles;
        end
    end

    // Accumulator and run statistics; cleared at launch, advanced on each counted RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            cycles <= '0;
            steps  <= '0;
        end else if (launch) begin
            acc    <= '0;
            cycles <= '0;
            steps  <= '0;
        end else if (advance) begin
            acc    <= sum[7:0];
            cycles <= cycles_inc;
            if (step_en) begin
                steps <= steps + CNT_W'(1);
            end
        end
    end

    // Lane array: seeded with index+1 at launch so no lane starts at zero, stepped on enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM; i++) begin
                lanes[i] <= '0;
            end
        end else if (launch) begin
            for (int i = 0; i < NUM; i++) begin
                lanes[i] <= W'(i + 1);
            end
        end else if (advance && step_en) begin
            for (int i = 0; i < NUM; i++) begin
                lanes[i] <= step_lane(lanes[i], mode_q);
            end
        end
    end

    // XOR signature of all lanes and the selected lane, ahead of the output registers.
    always_comb begin
        sig_next = '0;
        for (int i = 0; i < NUM; i++) begin
            sig_next = sig_next ^ lanes[i];
        end
        sample_next = '0;
        if (int'(sample_sel) < NUM) begin
            sample_next = lanes[sample_sel];
        end
    end

    // Observation registers run in every state so the host can read a stopped array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig         <= '0;
            sample_data <= '0;
        end else begin
            sig         <= sig_next;
            sample_data <= sample_next;
        end
    end

endmodule

// File: tb/tb_activity_counter_array.sv
// tb/tb_activity_counter_array.sv - vector table, random runs vs. arithmetic model, reset corner cases
module tb_activity_counter_array;

    localparam int           NUM   = 4;
    localparam int           W     = 8;
    localparam int           CNT_W = 16;
    localparam logic [W-1:0] POLY  = 8'hB8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic                    stop;
    logic [1:0]              mode;
    logic [8:0]              duty;
    logic [CNT_W-1:0]        run_cycles;
    logic [$clog2(NUM)-1:0]  sample_sel;
    logic                    busy;
    logic                    done;
    logic [CNT_W-1:0]        cycles;
    logic [CNT_W-1:0]        steps;
    logic [W-1:0]            sample_data;
    logic [W-1:0]            sig;

    int n_cmp = 0;
    int n_bad = 0;

    activity_counter_array #(
        .NUM   (NUM),
        .W     (W),
        .CNT_W (CNT_W),
        .POLY  (POLY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .duty        (duty),
        .run_cycles  (run_cycles),
        .sample_sel  (sample_sel),
        .busy        (busy),
        .done        (done),
        .cycles      (cycles),
        .steps       (steps),
        .sample_data (sample_data),
        .sig         (sig)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         duty;
        int         rc;
        int         stop_after;
        int         start_at;
        int         exp_cycles;
        int         exp_steps;
        int         exp_lane0;
        int         exp_sig;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Every lane is reseeded at start, so a lane is a pure function of its seed and step count.
    function automatic logic [W-1:0] model_lane(input int idx, input logic [1:0] m, input int s);
        logic [W-1:0] x;
        x = W'(idx + 1);
        case (m)
            2'd0: x = W'(idx + 1 + s);
            2'd1: x = W'(idx + 1 - s);
            2'd2: for (int k = 0; k < s; k++) x = (x >> 1) ^ (x[0] ? POLY : 8'h00);
            default: if (s % 2 == 1) x = ~x;
        endcase
        return x;
    endfunction

    function automatic int model_cycles(input int rc, input int stop_after);
        if (stop_after >= 0 && (rc == 0 || stop_after < rc)) return stop_after;
        return rc;
    endfunction

    task automatic do_run(input logic [1:0] m, input int d, input int rc, input int stop_after,
                          input int start_at, output int busy_cnt);
        int n;
        int guard;
        @(negedge clk);
        mode       = m;
        duty       = 9'(d);
        run_cycles = CNT_W'(rc);
        start      = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        busy_cnt = 0;
        n        = 0;
        guard    = 0;
        while (busy && guard < 5000) begin
            busy_cnt++;
            stop  = (n == stop_after);
            start = (n == start_at);
            @(negedge clk);
            n++;
            guard++;
        end
        stop  = 1'b0;
        start = 1'b0;
        if (guard >= 5000) check("run_timeout", 32'(guard), 32'(0));
        @(negedge clk);
    endtask

    task automatic check_run(input string tag, input logic [1:0] m, input int d, input int rc,
                             input int stop_after, input int busy_cnt);
        int ec;
        int es;
        logic [W-1:0] s;
        ec = model_cycles(rc, stop_after);
        es = (ec * d) / 256;
        check({tag, "_done"}, 32'(done), 32'(1));
        check({tag, "_busy"}, 32'(busy), 32'(0));
        check({tag, "_busy_len"}, 32'(busy_cnt), 32'((ec == stop_after) ? ec + 1 : ec));
        check({tag, "_cycles"}, 32'(cycles), 32'(ec));
        check({tag, "_steps"}, 32'(steps), 32'(es));
        s = '0;
        for (int i = 0; i < NUM; i++) s = s ^ model_lane(i, m, es);
        check({tag, "_sig"}, 32'(sig), 32'(s));
        for (int i = 0; i < NUM; i++) begin
            sample_sel = 2'(i);
            @(negedge clk);
            check({tag, "_lane"}, 32'(sample_data), 32'(model_lane(i, m, es)));
        end
    endtask

    initial begin
        int bc;
        int rc;
        int sa;
        int st;
        int d;
        logic [1:0] m;

        vecs[0] = '{2'd0, 256,  10, -1, -1,  10, 10, 8'h0B, 8'h04};
        vecs[1] = '{2'd0,  64, 256, -1, -1, 256, 64, 8'h41, 8'h04};
        vecs[2] = '{2'd0,   0,  20, -1, -1,  20,  0, 8'h01, 8'h04};
        vecs[3] = '{2'd2, 256,   1, -1, -1,   1,  1, 8'hB8, 8'h02};
        vecs[4] = '{2'd3, 256,   3, -1, -1,   3,  3, 8'hFE, 8'h04};
        vecs[5] = '{2'd1, 128,   7, -1, -1,   7,  3, 8'hFE, 8'h00};
        vecs[6] = '{2'd0, 256,   0, 50, 20,  50, 50, 8'h33, 8'h04};
        vecs[7] = '{2'd0, 256,  10,  9, -1,   9,  9, 8'h0A, 8'h00};

        rst        = 1'b1;
        start      = 1'b0;
        stop       = 1'b0;
        mode       = 2'd0;
        duty       = 9'd0;
        run_cycles = '0;
        sample_sel = '0;
        repeat (5) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_cycles", 32'(cycles), 32'(0));
        check("rst_steps", 32'(steps), 32'(0));
        check("rst_sig", 32'(sig), 32'(0));
        check("rst_sample", 32'(sample_data), 32'(0));
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_run(vecs[i].mode, vecs[i].duty, vecs[i].rc, vecs[i].stop_after, vecs[i].start_at, bc);
            check("vec_cycles", 32'(cycles), 32'(vecs[i].exp_cycles));
            check("vec_steps", 32'(steps), 32'(vecs[i].exp_steps));
            check("vec_sig", 32'(sig), 32'(vecs[i].exp_sig));
            sample_sel = 2'd0;
            @(negedge clk);
            check("vec_lane0", 32'(sample_data), 32'(vecs[i].exp_lane0));
            check_run("vec", vecs[i].mode, vecs[i].duty, vecs[i].rc, vecs[i].stop_after, bc);
        end

        for (int i = 0; i < 25; i++) begin
            m  = 2'($urandom_range(0, 3));
            d  = int'($urandom_range(0, 256));
            rc = int'($urandom_range(1, 300));
            sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, rc + 5)) : -1;
            st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, rc)) : -1;
            if (st >= model_cycles(rc, sa)) st = -1;
            do_run(m, d, rc, sa, st, bc);
            check_run("rnd", m, d, rc, sa, bc);
        end

        @(negedge clk);
        mode       = 2'd0;
        duty       = 9'd256;
        run_cycles = CNT_W'(100);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("arst_pre_busy", 32'(busy), 32'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_done", 32'(done), 32'(0));
        check("arst_cycles", 32'(cycles), 32'(0));
        check("arst_sig", 32'(sig), 32'(0));
        @(negedge clk);
        rst        = 1'b0;
        sample_sel = 2'd2;
        repeat (2) @(negedge clk);
        check("arst_post_done", 32'(done), 32'(0));
        check("arst_lane_sig", 32'(sig), 32'(0));
        check("arst_lane2", 32'(sample_data), 32'(0));

        do_run(vecs[0].mode, vecs[0].duty, vecs[0].rc, vecs[0].stop_after, vecs[0].start_at, bc);
        check("rerun_sig", 32'(sig), 32'(8'h04));
        sample_sel = 2'd3;
        @(negedge clk);
        check("rerun_lane3", 32'(sample_data), 32'(8'h0E));
        check_run("rerun", vecs[0].mode, vecs[0].duty, vecs[0].rc, vecs[0].stop_after, bc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/activity_counter_array.md
Name: activity_counter_array

Overview:
- Parametrised successor to the free-running counter array used for power characterisation.
- Provides NUM lanes of W-bit activity generators, selectable by mode: increment, decrement, Galois LFSR, or full invert.
- Step rate is set by a programmable duty accumulator, and a run/stop FSM bounds each run to an exact cycle budget.
- Sits at the top of the power-test fabric. The host (or bench) sets the mode, starts a run, and reads back cycle/step counts, a lane sample and an XOR signature.

Parameters:
- NUM, 512, number of lanes; must be ≤ 2^W − 1.
- W, 32, lane width in bits.
- CNT_W, 32, width of the run-length, cycle and step counters.
- POLY, 32'hB4BC_D35C (W bits), Galois LFSR feedback mask.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  launch a run; sampled in IDLE or DONE.
- stop  in  1  abort a run; sampled in RUN only.
- mode  in  2  0=INC, 1=DEC, 2=LFSR, 3=INVERT; latched at start.
- duty  in  9  step rate = duty/256, range 0..256; latched at start.
- run_cycles  in  CNT_W  run length in cycles; 0 = unbounded; latched at start.
- sample_sel  in  $clog2(NUM)  lane index to sample.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- cycles  out  CNT_W  RUN cycles elapsed in the current/last run.
- steps  out  CNT_W  lane step events in the current/last run.
- sample_data  out  W  registered lane[sample_sel].
- sig  out  W  registered XOR of all lanes.

Behaviour:
- Reset (async, rst=1):
  - State = IDLE.
  - All lanes, accumulator, cycles, steps, sample_data and sig = 0.
  - busy = 0, done = 0.
  - Latched mode/duty/run_cycles = 0.
  - Release is synchronous to the next clk edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE with start=1 at edge k:
    - Latch mode, duty, run_cycles.
    - Lane i ← (i+1) mod 2^W.
    - acc ← 0, cycles ← 0, steps ← 0.
    - State → RUN; busy=1 and done=0 from edge k.
  - RUN, each edge:
    - If stop=1: state → DONE; no step; cycles/steps unchanged.
    - Else: cycles += 1; sum = acc + duty (9 bits); en = sum[8]; acc ← sum[7:0].
    - If en: all lanes step per mode, steps += 1.
    - If run_cycles ≠ 0 and the new cycles value == run_cycles: state → DONE at that same edge.
  - start is ignored in RUN. stop is ignored in IDLE/DONE.
  - stop and final-cycle on the same edge: stop wins; that cycle is not counted.
- Lane step rules (mod 2^W):
  - INC: +1.
  - DEC: −1.
  - LFSR: (x>>1) ^ (x[0] ? POLY : 0).
  - INVERT: ~x.
- Duty:
  - duty=256 steps every RUN cycle.
  - duty=0 never steps.
  - Over any 256 consecutive RUN cycles from a start, exactly duty steps occur.
- Timing:
  - cycles and steps are registered, updating on the same edge as the RUN action.
  - sample_data and sig have 1-cycle latency from lane/sample_sel changes; they update in every state.
- Lanes hold their values in IDLE/DONE.
- cycles wraps mod 2^CNT_W when run_cycles=0.
- Reset mid-RUN: immediate return to the reset state, with no done pulse.

Test Plan:
- Reset, then hold rst=1 for 5 cycles → busy=0, done=0, cycles=0, sig=0, sample_data=0.
- NUM=4, W=8, mode=INC, duty=256, run_cycles=10, start 1 cycle:
  - busy high exactly 10 cycles, then done=1, cycles=10, steps=10.
  - Lanes = 11,12,13,14; sig=0x04.
  - sample_sel=3 → sample_data=14 one cycle later.
- duty=64, run_cycles=256, INC → steps=64, lane0=65. Then restart from DONE with duty=0, run_cycles=20 → steps=0, lane0=1, cycles=20.
- W=8, POLY=8'hB8, mode=LFSR, duty=256, run_cycles=1 → lane0 (seed 1) = 0xB8. Separately, mode=INVERT, run_cycles=3 → lane0=0xFE.
- run_cycles=0, start; pulse start at cycle 20 (ignored); stop at cycle 51 → done=1, cycles=50, busy dropped after the stop edge.
- Assert rst asynchronously mid-RUN (between edges) → busy=0 and lanes=0 before the next edge. After release, a fresh start behaves as in the INC scenario.
